// File: rtl/pll_lock_sequencer_pkg.sv
// Shared types and helpers for the PLL lock sequencer: state encoding and
// timer sizing.
package pll_lock_sequencer_pkg;

    typedef enum logic [1:0] {
        S_PLL_RST   = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABLE    = 2'd2,
        S_RUN       = 2'd3
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_lock_sync.sv
// Generic multi-flop synchronizer for an asynchronous status bit; clears to 0
// on the block's synchronous reset.
module lock_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clkin,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_ff;

    always_ff @(posedge clkin) begin
        if (reset) sync_ff <= '0;
        else       sync_ff <= {sync_ff[SYNC_STAGES-2:0], d};
    end

    assign q = sync_ff[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Sequences rPLL RESET, qualifies LOCK and releases the downstream HDMI reset
// once lock has been stable; re-arms the PLL on timeout or confirmed loss.
//
// state       | meaning
// S_PLL_RST   | pll_rst held high for PLL_RST_CYCLES
// S_WAIT_LOCK | pll_rst low, waiting up to LOCK_TIMEOUT for lock_s
// S_STABLE    | counting STABLE_CYCLES consecutive lock_s=1
// S_RUN       | sys_rst released, lock loss deglitched
module pll_lock_sequencer
    import pll_lock_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int PLL_RST_CYCLES  = 16,
    parameter int LOCK_TIMEOUT    = 65536,
    parameter int STABLE_CYCLES   = 1024,
    parameter int DEGLITCH_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             pll_lock,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic [CNT_W-1:0] relock_cnt,
    output logic [CNT_W-1:0] timeout_cnt
);

    localparam int TMR_MAX = max3(LOCK_TIMEOUT, STABLE_CYCLES, PLL_RST_CYCLES);
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int DEG_W   = $clog2(DEGLITCH_CYCLES + 1);

    state_e             state, state_d;
    logic [TMR_W-1:0]   timer;
    logic [DEG_W-1:0]   deg, deg_d;
    logic               lock_s;
    logic               timeout_evt, relock_evt;
    logic               pll_rst_d, sys_rst_d;

    lock_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
        .clkin (clkin),
        .reset (reset),
        .d     (pll_lock),
        .q     (lock_s)
    );

    always_ff @(posedge clkin) begin
        if (reset) begin
            state       <= S_PLL_RST;
            timer       <= '0;
            deg         <= '0;
            pll_rst     <= 1'b1;
            sys_rst     <= 1'b1;
            ready       <= 1'b0;
            relock_cnt  <= '0;
            timeout_cnt <= '0;
        end else begin
            state   <= state_d;
            deg     <= deg_d;
            pll_rst <= pll_rst_d;
            sys_rst <= sys_rst_d;
            ready   <= ~sys_rst_d;
            // Timer parks in RUN; only the deglitch counter matters there.
            if (state_d != state)  timer <= '0;
            else if (state != S_RUN) timer <= timer + 1'b1;
            if (timeout_evt && (timeout_cnt != '1)) timeout_cnt <= timeout_cnt + 1'b1;
            if (relock_evt && (relock_cnt != '1))   relock_cnt  <= relock_cnt + 1'b1;
        end
    end

    always_comb begin
        state_d     = state;
        deg_d       = '0;
        timeout_evt = 1'b0;
        relock_evt  = 1'b0;
        case (state)
            S_PLL_RST: begin
                if (timer == TMR_W'(PLL_RST_CYCLES - 1)) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                // Lock takes priority over a coincident timeout.
                if (lock_s) begin
                    state_d = S_STABLE;
                end else if (timer == TMR_W'(LOCK_TIMEOUT - 1)) begin
                    state_d     = S_PLL_RST;
                    timeout_evt = 1'b1;
                end
            end
            S_STABLE: begin
                if (!lock_s)                                 state_d = S_WAIT_LOCK;
                else if (timer == TMR_W'(STABLE_CYCLES - 1)) state_d = S_RUN;
            end
            S_RUN: begin
                if (lock_s) begin
                    deg_d = '0;
                end else if (deg == DEG_W'(DEGLITCH_CYCLES - 1)) begin
                    state_d    = S_PLL_RST;
                    relock_evt = 1'b1;
                end else begin
                    deg_d = deg + 1'b1;
                end
            end
            default: state_d = S_PLL_RST;
        endcase
    end

    always_comb begin
        pll_rst_d = (state_d == S_PLL_RST);
        sys_rst_d = (state_d != S_RUN);
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with short timing parameters; each
// step advances a known number of clkin edges and checks hand-computed values.
module tb_pll_lock_sequencer;

    localparam int CNT_W = 4;

    logic             clkin = 1'b0;
    logic             reset;
    logic             pll_lock;
    logic             pll_rst, sys_rst, ready;
    logic [CNT_W-1:0] relock_cnt, timeout_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clkin = ~clkin;

    pll_lock_sequencer #(
        .SYNC_STAGES     (2),
        .PLL_RST_CYCLES  (4),
        .LOCK_TIMEOUT    (32),
        .STABLE_CYCLES   (8),
        .DEGLITCH_CYCLES (3),
        .CNT_W           (CNT_W)
    ) dut (
        .clkin       (clkin),
        .reset       (reset),
        .pll_lock    (pll_lock),
        .pll_rst     (pll_rst),
        .sys_rst     (sys_rst),
        .ready       (ready),
        .relock_cnt  (relock_cnt),
        .timeout_cnt (timeout_cnt)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clkin);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset    = 1'b1;
        pll_lock = 1'b0;
        tick(2);
        check("rst_pll_rst", pll_rst, 1);
        check("rst_sys_rst", sys_rst, 1);
        check("rst_ready", ready, 0);
        check("rst_relock", relock_cnt, 0);
        check("rst_timeout", timeout_cnt, 0);

        // 1: pll_rst 4 high, 32 low, then a timeout re-pulse
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("t1_pll_rst_hi", pll_rst, 1);
        end
        tick(1);
        check("t1_pll_rst_fall", pll_rst, 0);
        for (int i = 0; i < 31; i++) begin
            tick(1);
            check("t1_wait_low", pll_rst, 0);
        end
        check("t1_timeout_pre", timeout_cnt, 0);
        tick(1);
        check("t1_repulse", pll_rst, 1);
        check("t1_timeout_cnt", timeout_cnt, 1);
        check("t1_sys_rst", sys_rst, 1);

        reset = 1'b1;
        tick(1);
        check("rst2_timeout", timeout_cnt, 0);
        reset = 1'b0;

        // 2: lock 5 cycles after pll_rst falls, release 10 cycles after first sample
        tick(3);
        check("t2_pll_rst_hi", pll_rst, 1);
        tick(1);
        check("t2_pll_rst_fall", pll_rst, 0);
        tick(4);
        pll_lock = 1'b1;
        tick(10);
        check("t2_sys_rst_held", sys_rst, 1);
        check("t2_ready_low", ready, 0);
        tick(1);
        check("t2_sys_rst_rel", sys_rst, 0);
        check("t2_ready", ready, 1);
        check("t2_relock", relock_cnt, 0);
        check("t2_timeout", timeout_cnt, 0);

        // 4: 2-cycle glitch ignored, 3-cycle loss re-arms the PLL
        pll_lock = 1'b0;
        tick(2);
        pll_lock = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("t4_glitch_sys_rst", sys_rst, 0);
            check("t4_glitch_ready", ready, 1);
        end
        pll_lock = 1'b0;
        tick(3);
        pll_lock = 1'b1;
        tick(1);
        check("t4_loss_pending", sys_rst, 0);
        tick(1);
        check("t4_loss_sys_rst", sys_rst, 1);
        check("t4_loss_pll_rst", pll_rst, 1);
        check("t4_loss_ready", ready, 0);
        check("t4_relock", relock_cnt, 1);

        // 3: one-cycle drop at stable count 5 restarts the full 8-cycle qualification
        tick(5);
        check("t3_in_stable_sys", sys_rst, 1);
        check("t3_in_stable_pll", pll_rst, 0);
        tick(3);
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        tick(4);
        check("t3_no_early_rel", sys_rst, 1);
        tick(6);
        check("t3_still_held", sys_rst, 1);
        tick(1);
        check("t3_release", sys_rst, 0);
        check("t3_timeout", timeout_cnt, 0);

        // 6: lock_s rises on the timeout cycle; lock wins
        pll_lock = 1'b0;
        tick(4);
        check("t6_run_hold", sys_rst, 0);
        tick(1);
        check("t6_loss", sys_rst, 1);
        check("t6_relock", relock_cnt, 2);
        tick(4);
        check("t6_wait", pll_rst, 0);
        tick(29);
        pll_lock = 1'b1;
        tick(2);
        check("t6_pre_edge", pll_rst, 0);
        tick(1);
        check("t6_no_repulse", pll_rst, 0);
        check("t6_timeout", timeout_cnt, 0);
        tick(8);
        check("t6_release", sys_rst, 0);

        // 5: timeout counter saturation, then reset mid-STABLE
        pll_lock = 1'b0;
        tick(5);
        check("t5_relock", relock_cnt, 3);
        check("t5_pll_rst", pll_rst, 1);
        tick(36 * 15 - 1);
        check("t5_cnt14", timeout_cnt, 14);
        tick(1);
        check("t5_cnt15", timeout_cnt, 15);
        tick(36 * 5);
        check("t5_saturated", timeout_cnt, 15);
        check("t5_repulse", pll_rst, 1);
        pll_lock = 1'b1;
        tick(5);
        check("t5_stable_pll", pll_rst, 0);
        check("t5_stable_sys", sys_rst, 1);
        tick(3);
        reset = 1'b1;
        tick(1);
        check("t5_rst_pll_rst", pll_rst, 1);
        check("t5_rst_sys_rst", sys_rst, 1);
        check("t5_rst_ready", ready, 0);
        check("t5_rst_relock", relock_cnt, 0);
        check("t5_rst_timeout", timeout_cnt, 0);
        reset = 1'b0;
        tick(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
